// File: rtl/cnn_pkg.sv
// Shared state encoding and constants for the 3x3 CNN window generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

  // Window is K x K pixels.
  localparam int K = 3;

  // Default index and pixel widths.
  localparam int DEF_W_SIZE = 12;
  localparam int DEF_W_DATA = 8;

  // Frame-tracking states: waiting for a frame, priming two lines, producing windows.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } cnn_state_t;

endpackage

// File: rtl/cnn_line_mem.sv
// One line of pixel history: register array, asynchronous read, synchronous write.
// Latency: read is combinational from addr; a write lands at the next clk edge.
// Backpressure: none; the caller gates we.
module cnn_line_mem
  import cnn_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int W_DATA = DEF_W_DATA,
  parameter int W_ADDR = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [W_ADDR-1:0] addr,
  input  logic [W_DATA-1:0] wdata,
  output logic [W_DATA-1:0] rdata
);

  logic [W_DATA-1:0] mem [DEPTH];

  // Old contents are visible during the write cycle, giving read-before-write.
  assign rdata = mem[addr];

  // Contents are deliberately not reset; the fill phase overwrites them before use.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/cnn_win3x3.sv
// 3x3 sliding-window generator over a raster pixel stream (two line buffers + column shift regs).
// Latency: window valid one cycle after the accepted pixel at its bottom-right corner.
// Backpressure: none; i_data_run=0 freezes all state. Macro CNN_WIN_STRIDE2_EN selects stride 2.
module cnn_win3x3
  import cnn_pkg::*;
#(
  parameter int W_SIZE = DEF_W_SIZE,
  parameter int W_DATA = DEF_W_DATA,
  parameter int MAX_W  = 2048
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic                    i_data_run,
  input  logic [W_SIZE-1:0]       i_row,
  input  logic [W_SIZE-1:0]       i_col,
  input  logic                    i_end_frame,
  input  logic [W_DATA-1:0]       i_pix,
  output logic                    o_win_valid,
  output logic [K*K*W_DATA-1:0]   o_win,
  output logic [W_SIZE-1:0]       o_win_row,
  output logic [W_SIZE-1:0]       o_win_col,
  output logic                    o_frame_done
);

  localparam int W_ADDR = $clog2(MAX_W);

  cnn_state_t state_q, state_d;

  logic [W_ADDR-1:0]      lb_addr;
  logic [W_DATA-1:0]      lb0_rd;
  logic [W_DATA-1:0]      lb1_rd;
  logic [K*W_DATA-1:0]    col_new;
  logic [K*W_DATA-1:0]    col_sr [K];
  logic [K*K*W_DATA-1:0]  win_cur;
  logic [K*K*W_DATA-1:0]  win_hold_q;
  logic                   win_emit;
  logic                   fd_nxt;
  logic                   stride_ok;
  logic [W_SIZE-1:0]      row_off;
  logic [W_SIZE-1:0]      col_off;
  logic [W_SIZE-1:0]      row_nxt;
  logic [W_SIZE-1:0]      col_nxt;

  assign lb_addr = i_col[W_ADDR-1:0];

  // LB0 holds row r-1; on acceptance it takes the new pixel.
  cnn_line_mem #(.DEPTH(MAX_W), .W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_lb0 (
    .clk   (clk),
    .we    (i_data_run),
    .addr  (lb_addr),
    .wdata (i_pix),
    .rdata (lb0_rd)
  );

  // LB1 holds row r-2; on acceptance it takes LB0's outgoing value.
  cnn_line_mem #(.DEPTH(MAX_W), .W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_lb1 (
    .clk   (clk),
    .we    (i_data_run),
    .addr  (lb_addr),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Column element 0 is the top row (r-2), element K-1 the current row.
  assign col_new = {i_pix, lb0_rd, lb1_rd};

`ifdef CNN_WIN_STRIDE2_EN
  // (r-2) and (c-2) are even exactly when r and c are even.
  assign stride_ok = ~i_row[0] & ~i_col[0];
`else
  assign stride_ok = 1'b1;
`endif

  // Output coordinates; only captured when r>=2 and c>=2, so no wrap is ever stored.
  assign row_off = i_row - W_SIZE'(2);
  assign col_off = i_col - W_SIZE'(2);
`ifdef CNN_WIN_STRIDE2_EN
  assign row_nxt = {1'b0, row_off[W_SIZE-1:1]};
  assign col_nxt = {1'b0, col_off[W_SIZE-1:1]};
`else
  assign row_nxt = row_off;
  assign col_nxt = col_off;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state plus window-emit and frame-done decisions for the accepted pixel.
  always_comb begin
    state_d  = state_q;
    win_emit = 1'b0;
    fd_nxt   = 1'b0;
    if (i_data_run) begin
      if (state_q == ST_RUN) begin
        win_emit = (i_row >= W_SIZE'(2)) && (i_col >= W_SIZE'(2)) &&
                   (i_col < q_width) && stride_ok;
        fd_nxt   = i_end_frame;
      end
      if (i_row == '0 && i_col == '0) begin
        // Pixel (0,0) always restarts, discarding any partial frame.
        state_d = ST_FILL;
      end else if (i_end_frame) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (i_row == '0) state_d = ST_FILL;
          ST_FILL: if (i_row == W_SIZE'(2) && i_col == '0) state_d = ST_RUN;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Column shift registers: oldest column at index 0, newest at K-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < K; k++) col_sr[k] <= '0;
    end else if (i_data_run) begin
      for (int k = 0; k < K-1; k++) col_sr[k] <= col_sr[k+1];
      col_sr[K-1] <= col_new;
    end
  end

  // Rearrange the stored columns into the row-major window layout.
  always_comb begin
    win_cur = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_cur[W_DATA*(K*i+j) +: W_DATA] = col_sr[j][W_DATA*i +: W_DATA];
      end
    end
  end

  // Window is live from the shift registers when valid, otherwise the last one shown.
  assign o_win = o_win_valid ? win_cur : win_hold_q;

  // Remember the window on the output so later shifts do not disturb it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) win_hold_q <= '0;
    else       win_hold_q <= o_win;
  end

  // Registered valid, frame-done pulse and held output coordinates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_win_row    <= '0;
      o_win_col    <= '0;
    end else begin
      o_win_valid  <= win_emit;
      o_frame_done <= fd_nxt;
      if (win_emit) begin
        o_win_row <= row_nxt;
        o_win_col <= col_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cnn_win3x3.sv
// Randomized self-checking bench for cnn_win3x3 against a frame-array reference model.
// Latency: checks the one-cycle window latency on every cycle.
// Backpressure: exercises i_data_run stalls and line gaps.
module tb_cnn_win3x3;
  import cnn_pkg::*;

  localparam int WS = 12;
  localparam int WD = 8;
  localparam int MW = 2048;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [WS-1:0]  q_width = '0;
  logic           i_data_run = 1'b0;
  logic [WS-1:0]  i_row = '0;
  logic [WS-1:0]  i_col = '0;
  logic           i_end_frame = 1'b0;
  logic [WD-1:0]  i_pix = '0;
  logic           o_win_valid;
  logic [9*WD-1:0] o_win;
  logic [WS-1:0]  o_win_row;
  logic [WS-1:0]  o_win_col;
  logic           o_frame_done;

  cnn_win3x3 #(.W_SIZE(WS), .W_DATA(WD), .MAX_W(MW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .q_width      (q_width),
    .i_data_run   (i_data_run),
    .i_row        (i_row),
    .i_col        (i_col),
    .i_end_frame  (i_end_frame),
    .i_pix        (i_pix),
    .o_win_valid  (o_win_valid),
    .o_win        (o_win),
    .o_win_row    (o_win_row),
    .o_win_col    (o_win_col),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    bit            vld;
    bit            fd;
    logic [9*WD-1:0] win;
    logic [WS-1:0] row;
    logic [WS-1:0] col;
  } exp_t;

  typedef struct {
    logic [9*WD-1:0] win;
    logic [WS-1:0] row;
    logic [WS-1:0] col;
    bit            fd;
  } obs_t;

  exp_t expq[$];
  obs_t log_q[$];
  int   fd_cnt = 0;
  int   tests = 0;
  int   fails = 0;
  int   pix [0:15][0:15];

  logic [9*WD-1:0] last_win = '0;
  logic [WS-1:0]   last_row = '0;
  logic [WS-1:0]   last_col = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT outputs to the model on every cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    while (expq.size() > 0 && expq[0].due < cyc) begin
      e = expq.pop_front();
      tests++;
      fails++;
      $display("FAIL missed_event: due cycle %0d not observed, now %0d", e.due, cyc);
    end
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("win_valid", 128'(o_win_valid), 128'(e.vld));
      chk("frame_done", 128'(o_frame_done), 128'(e.fd));
      if (e.vld) begin
        chk("win_data", 128'(o_win), 128'(e.win));
        chk("win_row", 128'(o_win_row), 128'(e.row));
        chk("win_col", 128'(o_win_col), 128'(e.col));
        last_win = e.win;
        last_row = e.row;
        last_col = e.col;
      end else begin
        chk("hold_win", 128'(o_win), 128'(last_win));
      end
    end else begin
      chk("idle_valid", 128'(o_win_valid), 128'(0));
      chk("idle_frame_done", 128'(o_frame_done), 128'(0));
      chk("hold_win", 128'(o_win), 128'(last_win));
      chk("hold_row", 128'(o_win_row), 128'(last_row));
      chk("hold_col", 128'(o_win_col), 128'(last_col));
    end
    if (o_win_valid) log_q.push_back('{win: o_win, row: o_win_row, col: o_win_col, fd: o_frame_done});
    if (o_frame_done) fd_cnt++;
  end

  // Reference model: which windows a pixel completes, straight from the frame array.
  task automatic model_push(input int r, input int c, input bit endf);
    exp_t e;
    bit   emit;
`ifdef CNN_WIN_STRIDE2_EN
    emit = (r >= 2) && (c >= 2) && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`else
    emit = (r >= 2) && (c >= 2);
`endif
    if (emit || endf) begin
      e.due = cyc + 1;
      e.vld = emit;
      e.fd  = endf;
      e.win = '0;
      e.row = '0;
      e.col = '0;
      if (emit) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[WD*(3*i+j) +: WD] = WD'(pix[r-2+i][c-2+j]);
`ifdef CNN_WIN_STRIDE2_EN
        e.row = WS'((r - 2) / 2);
        e.col = WS'((c - 2) / 2);
`else
        e.row = WS'(r - 2);
        e.col = WS'(c - 2);
`endif
      end
      expq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_data_run  = 1'b0;
      i_row       = WS'($urandom_range(0, 15));
      i_col       = WS'($urandom_range(0, 15));
      i_end_frame = 1'($urandom_range(0, 1));
      i_pix       = WD'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_pix(input int r, input int c, input bit endf);
    @(posedge clk); #1;
    i_data_run  = 1'b1;
    i_row       = WS'(r);
    i_col       = WS'(c);
    i_end_frame = endf;
    i_pix       = WD'(pix[r][c]);
    model_push(r, c, endf);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    i_data_run = 1'b0;
    expq.delete();
    last_win = '0;
    last_row = '0;
    last_col = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(o_win_valid), 128'(0));
    chk("rst_frame_done", 128'(o_frame_done), 128'(0));
    chk("rst_win", 128'(o_win), 128'(0));
    chk("rst_row", 128'(o_win_row), 128'(0));
    chk("rst_col", 128'(o_win_col), 128'(0));
    rstn = 1'b1;
  endtask

  // mode 0: continuous, 1: 7-cycle gap between lines, 2: random stalls.
  // Returns early into reset when (ar,ac) is reached.
  task automatic run_frame(input int h, input int w, input int mode, input bit rnd,
                           input int ar, input int ac);
    q_width = WS'(w);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        pix[r][c] = rnd ? int'($urandom_range(0, 255)) : r * w + c;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r == ar && c == ac) begin
          do_reset();
          return;
        end
        if (mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        drive_pix(r, c, (r == h - 1) && (c == w - 1));
      end
      if (mode == 1 && r != h - 1) idle(7);
    end
  endtask

  function automatic int n_exp(input int h, input int w);
`ifdef CNN_WIN_STRIDE2_EN
    return ((h - 1) / 2) * ((w - 1) / 2);
`else
    return (h - 2) * (w - 2);
`endif
  endfunction

  function automatic logic [9*WD-1:0] packw(input int v[9]);
    logic [9*WD-1:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[WD*k +: WD] = WD'(v[k]);
    return p;
  endfunction

  task automatic check_4x4_literals(input string tag);
    int lf[9];
    int ll[9];
    lf = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    ll = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    chk({tag, "_count"}, 128'(log_q.size()), 128'(4));
    if (log_q.size() == 4) begin
      chk({tag, "_first_win"}, 128'(log_q[0].win), 128'(packw(lf)));
      chk({tag, "_first_row"}, 128'(log_q[0].row), 128'(0));
      chk({tag, "_first_col"}, 128'(log_q[0].col), 128'(0));
      chk({tag, "_first_fd"}, 128'(log_q[0].fd), 128'(0));
      chk({tag, "_last_win"}, 128'(log_q[3].win), 128'(packw(ll)));
      chk({tag, "_last_row"}, 128'(log_q[3].row), 128'(1));
      chk({tag, "_last_col"}, 128'(log_q[3].col), 128'(1));
      chk({tag, "_last_fd"}, 128'(log_q[3].fd), 128'(1));
    end
  endtask

  initial begin
    do_reset();
    idle(2);

    // Continuous 4x4 ramp frame.
    log_q.delete(); fd_cnt = 0;
    run_frame(4, 4, 0, 1'b0, -1, -1);
    idle(3);
`ifndef CNN_WIN_STRIDE2_EN
    check_4x4_literals("cont4x4");
`endif
    chk("cont4x4_fd_cnt", 128'(fd_cnt), 128'(1));

    // Same frame with 7-cycle gaps between lines.
    log_q.delete(); fd_cnt = 0;
    run_frame(4, 4, 1, 1'b0, -1, -1);
    idle(3);
`ifndef CNN_WIN_STRIDE2_EN
    check_4x4_literals("gap4x4");
`else
    chk("gap4x4_count", 128'(log_q.size()), 128'(n_exp(4, 4)));
`endif

    // Width 3, height 5: one window per row, column 0.
    log_q.delete();
    run_frame(5, 3, 0, 1'b1, -1, -1);
    idle(3);
    chk("w3_count", 128'(log_q.size()), 128'(n_exp(5, 3)));
    for (int k = 0; k < log_q.size(); k++) chk("w3_col", 128'(log_q[k].col), 128'(0));

    // Reset at (2,1) of a 5x5 frame, then a fresh random 5x5 frame.
    log_q.delete();
    run_frame(5, 5, 0, 1'b1, 2, 1);
    chk("abort_no_windows", 128'(log_q.size()), 128'(0));
    run_frame(5, 5, 0, 1'b1, -1, -1);
    idle(3);
    chk("after_rst_count", 128'(log_q.size()), 128'(n_exp(5, 5)));

    // Back-to-back random 4x4 frames.
    log_q.delete(); fd_cnt = 0;
    run_frame(4, 4, 0, 1'b1, -1, -1);
    run_frame(4, 4, 0, 1'b1, -1, -1);
    idle(3);
    chk("b2b_count", 128'(log_q.size()), 128'(2 * n_exp(4, 4)));
    chk("b2b_fd_cnt", 128'(fd_cnt), 128'(2));

    // Random sizes with random stalls.
    for (int f = 0; f < 8; f++) begin
      int h;
      int w;
      h = $urandom_range(3, 8);
      w = $urandom_range(3, 12);
      log_q.delete();
      run_frame(h, w, 2, 1'b1, -1, -1);
      idle(3);
      chk("rand_count", 128'(log_q.size()), 128'(n_exp(h, w)));
    end

`ifdef CNN_WIN_STRIDE2_EN
    // Stride 2 on a 5x5 ramp: centres at input (1,1),(1,3),(3,1),(3,3).
    log_q.delete(); fd_cnt = 0;
    run_frame(5, 5, 0, 1'b0, -1, -1);
    idle(3);
    chk("s2_count", 128'(log_q.size()), 128'(4));
    if (log_q.size() == 4) begin
      chk("s2_c0", 128'(log_q[0].win[WD*4 +: WD]), 128'(6));
      chk("s2_c1", 128'(log_q[1].win[WD*4 +: WD]), 128'(8));
      chk("s2_c2", 128'(log_q[2].win[WD*4 +: WD]), 128'(16));
      chk("s2_c3", 128'(log_q[3].win[WD*4 +: WD]), 128'(18));
      chk("s2_rc1", 128'({log_q[1].row, log_q[1].col}), 128'({12'd0, 12'd1}));
      chk("s2_rc2", 128'({log_q[2].row, log_q[2].col}), 128'({12'd1, 12'd0}));
      chk("s2_rc3", 128'({log_q[3].row, log_q[3].col}), 128'({12'd1, 12'd1}));
      chk("s2_fd", 128'(log_q[3].fd), 128'(1));
    end
`endif

    idle(5);
    chk("queue_drained", 128'(expq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
